// File: rtl/dsram_arb.sv
// dsram_arb: two-requester arbiter in front of a single-port data SRAM.
// Every access runs IDLE -> SETUP -> STROBE (STROBE_CYCLES clocks, CS_D low) -> HOLD.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   A_* / B_*                requester A (CPU) and B (loader): level REQ held until ACK,
//                            WE/ADDR/WDATA request fields, one-cycle ACK, per-requester RDATA
//   WD, RD, CS_D, DIN, ADDR  SRAM control/data, all registered (CS_D active low)
//   DOUT                     SRAM read data
//   BUSY                     high whenever the FSM is not in IDLE
module dsram_arb #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A_REQ,
  input  logic       A_WE,
  input  logic [6:0] A_ADDR,
  input  logic [7:0] A_WDATA,
  output logic       A_ACK,
  output logic [7:0] A_RDATA,
  input  logic       B_REQ,
  input  logic       B_WE,
  input  logic [6:0] B_ADDR,
  input  logic [7:0] B_WDATA,
  output logic       B_ACK,
  output logic [7:0] B_RDATA,
  output logic       WD,
  output logic       RD,
  output logic       CS_D,
  output logic [7:0] DIN,
  output logic [6:0] ADDR,
  input  logic [7:0] DOUT,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [1:0] CNT_LOAD = 2'(STROBE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       last_b_q, last_b_d;   // 1: B was granted most recently
  logic       win_b_q, win_b_d;     // 1: current access belongs to B
  logic       wd_q, wd_d;
  logic       rd_q, rd_d;
  logic       csn_q, csn_d;
  logic [7:0] din_q, din_d;
  logic [6:0] addr_q, addr_d;
  logic       a_ack_q, a_ack_d;
  logic       b_ack_q, b_ack_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;
  logic       busy_q, busy_d;
  logic       gnt_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    win_b_d   = win_b_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    csn_d     = 1'b1;
    din_d     = din_q;
    addr_d    = addr_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    // B wins when alone, or on a conflict if A was granted last.
    gnt_b     = B_REQ && (!A_REQ || !last_b_q);

    unique case (state_q)
      IDLE: begin
        wd_d = 1'b0;
        rd_d = 1'b0;
        if (A_REQ || B_REQ) begin
          // The SETUP-cycle output registers double as the request latch.
          win_b_d  = gnt_b;
          last_b_d = gnt_b;
          addr_d   = gnt_b ? B_ADDR  : A_ADDR;
          din_d    = gnt_b ? B_WDATA : A_WDATA;
          wd_d     = gnt_b ? B_WE    : A_WE;
          rd_d     = gnt_b ? !B_WE   : !A_WE;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        csn_d   = 1'b0;
        cnt_d   = CNT_LOAD;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 2'd0) begin
          state_d = HOLD;
          a_ack_d = !win_b_q;
          b_ack_d = win_b_q;
          if (rd_q) begin
            if (win_b_q) b_rdata_d = DOUT;
            else         a_rdata_d = DOUT;
          end
        end else begin
          csn_d = 1'b0;
          cnt_d = cnt_q - 2'd1;
        end
      end
      HOLD: begin
        wd_d    = 1'b0;
        rd_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      win_b_q   <= 1'b0;
      wd_q      <= 1'b0;
      rd_q      <= 1'b0;
      csn_q     <= 1'b1;
      din_q     <= '0;
      addr_q    <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      win_b_q   <= win_b_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
      csn_q     <= csn_d;
      din_q     <= din_d;
      addr_q    <= addr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign WD      = wd_q;
  assign RD      = rd_q;
  assign CS_D    = csn_q;
  assign DIN     = din_q;
  assign ADDR    = addr_q;
  assign A_ACK   = a_ack_q;
  assign B_ACK   = b_ack_q;
  assign A_RDATA = a_rdata_q;
  assign B_RDATA = b_rdata_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_dsram_arb.sv
// Self-checking bench for dsram_arb: one instance with STROBE_CYCLES=1 (table-driven
// accesses plus arbitration/reset sequences) and one with STROBE_CYCLES=3.
module tb_dsram_arb;

  localparam int S1 = 1;
  localparam int S3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // ---------------- instance with STROBE_CYCLES = 1 ----------------
  logic       rst1;
  logic       a_req1, a_we1, b_req1, b_we1;
  logic [6:0] a_addr1, b_addr1, addr1;
  logic [7:0] a_wdata1, b_wdata1, a_rdata1, b_rdata1, din1, dout1;
  logic       a_ack1, b_ack1, wd1, rd1, csn1, busy1;
  logic [7:0] mem1 [128];

  dsram_arb #(.STROBE_CYCLES(S1)) dut1 (
    .CLK(clk), .RST(rst1),
    .A_REQ(a_req1), .A_WE(a_we1), .A_ADDR(a_addr1), .A_WDATA(a_wdata1),
    .A_ACK(a_ack1), .A_RDATA(a_rdata1),
    .B_REQ(b_req1), .B_WE(b_we1), .B_ADDR(b_addr1), .B_WDATA(b_wdata1),
    .B_ACK(b_ack1), .B_RDATA(b_rdata1),
    .WD(wd1), .RD(rd1), .CS_D(csn1), .DIN(din1), .ADDR(addr1),
    .DOUT(dout1), .BUSY(busy1)
  );

  always @(posedge clk) if (!csn1 && wd1) mem1[addr1] <= din1;
  assign dout1 = mem1[addr1];

  // ---------------- instance with STROBE_CYCLES = 3 ----------------
  logic       rst3;
  logic       a_req3, a_we3, b_req3, b_we3;
  logic [6:0] a_addr3, b_addr3, addr3;
  logic [7:0] a_wdata3, b_wdata3, a_rdata3, b_rdata3, din3, dout3;
  logic       a_ack3, b_ack3, wd3, rd3, csn3, busy3;
  logic [7:0] mem3 [128];

  dsram_arb #(.STROBE_CYCLES(S3)) dut3 (
    .CLK(clk), .RST(rst3),
    .A_REQ(a_req3), .A_WE(a_we3), .A_ADDR(a_addr3), .A_WDATA(a_wdata3),
    .A_ACK(a_ack3), .A_RDATA(a_rdata3),
    .B_REQ(b_req3), .B_WE(b_we3), .B_ADDR(b_addr3), .B_WDATA(b_wdata3),
    .B_ACK(b_ack3), .B_RDATA(b_rdata3),
    .WD(wd3), .RD(rd3), .CS_D(csn3), .DIN(din3), .ADDR(addr3),
    .DOUT(dout3), .BUSY(busy3)
  );

  always @(posedge clk) if (!csn3 && wd3) mem3[addr3] <= din3;
  assign dout3 = mem3[addr3];

  // ---------------- helpers ----------------
  logic [7:0] exp_ra, exp_rb;

  typedef struct {
    bit         who;     // 0: A, 1: B
    bit         we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;  // expected read data (reads only)
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset1(input string nm);
    chk({nm, " CS_D"}, 32'(csn1), 1);
    chk({nm, " WD"}, 32'(wd1), 0);
    chk({nm, " RD"}, 32'(rd1), 0);
    chk({nm, " ADDR"}, 32'(addr1), 0);
    chk({nm, " DIN"}, 32'(din1), 0);
    chk({nm, " ACKs"}, 32'({a_ack1, b_ack1}), 0);
    chk({nm, " A_RDATA"}, 32'(a_rdata1), 0);
    chk({nm, " B_RDATA"}, 32'(b_rdata1), 0);
    chk({nm, " BUSY"}, 32'(busy1), 0);
  endtask

  // Waits (bounded) on dut1 for an ACK. snap = {WD,RD,ADDR,DIN} at the first strobe
  // cycle; unstable flags any change of those through the strobe and the ACK cycle.
  task automatic wait_ack1(output int k, output logic [1:0] acks, output int lows,
                           output logic [16:0] snap, output bit unstable);
    k = 0; acks = 2'b00; lows = 0; snap = '0; unstable = 1'b0;
    while (acks == 2'b00 && k < 30) begin
      @(negedge clk);
      k++;
      if (!csn1) begin
        if (lows == 0) snap = {wd1, rd1, addr1, din1};
        else if (snap != {wd1, rd1, addr1, din1}) unstable = 1'b1;
        lows++;
      end
      acks = {a_ack1, b_ack1};
    end
    if (acks != 2'b00 && lows > 0 && snap != {wd1, rd1, addr1, din1}) unstable = 1'b1;
  endtask

  task automatic access1(input bit who, input bit we, input logic [6:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd, input string nm);
    int k, lows;
    logic [1:0] acks;
    logic [16:0] snap;
    bit unstable;
    @(negedge clk);
    if (!who) begin
      a_req1 = 1'b1; a_we1 = we; a_addr1 = addr; a_wdata1 = wdata;
    end else begin
      b_req1 = 1'b1; b_we1 = we; b_addr1 = addr; b_wdata1 = wdata;
    end
    wait_ack1(k, acks, lows, snap, unstable);
    if (!who) a_req1 = 1'b0; else b_req1 = 1'b0;
    if (!we) begin
      if (!who) exp_ra = exp_rd; else exp_rb = exp_rd;
    end
    chk({nm, " ack owner"}, 32'(acks), who ? 2 'b01 : 2'b10);
    chk({nm, " latency"}, k, S1 + 2);
    chk({nm, " strobe len"}, lows, S1);
    chk({nm, " bus"}, 32'(snap), 32'({we, !we, addr, wdata}));
    chk({nm, " stable"}, 32'(unstable), 0);
    chk({nm, " CS_D at ack"}, 32'(csn1), 1);
    chk({nm, " A_RDATA"}, 32'(a_rdata1), 32'(exp_ra));
    chk({nm, " B_RDATA"}, 32'(b_rdata1), 32'(exp_rb));
    @(negedge clk);
    chk({nm, " ack pulse"}, 32'({a_ack1, b_ack1}), 0);
    chk({nm, " idle"}, 32'(busy1), 0);
  endtask

  // One A access on dut3; request fields are scrambled two cycles after issue.
  task automatic access3(input bit we, input logic [6:0] addr, input logic [7:0] wdata,
                         output int k, output int lows, output bit bad);
    k = 0; lows = 0; bad = 1'b0;
    @(negedge clk);
    a_req3 = 1'b1; a_we3 = we; a_addr3 = addr; a_wdata3 = wdata;
    while (!a_ack3 && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        a_we3 = !we; a_addr3 = ~addr; a_wdata3 = ~wdata;
      end
      if (!csn3) begin
        lows++;
        if (addr3 != addr || din3 != wdata || wd3 != we || rd3 != !we) bad = 1'b1;
      end
    end
    a_req3 = 1'b0;
  endtask

  initial begin
    int k, lows, quiet;
    logic [1:0] acks;
    logic [16:0] snap;
    bit unstable, bad;

    tbl[0] = '{who: 1'b0, we: 1'b1, addr: 7'd0,    wdata: 8'h01, exp_rd: 8'h00};
    tbl[1] = '{who: 1'b1, we: 1'b1, addr: 7'd1,    wdata: 8'h03, exp_rd: 8'h00};
    tbl[2] = '{who: 1'b0, we: 1'b0, addr: 7'd1,    wdata: 8'h00, exp_rd: 8'h03};
    tbl[3] = '{who: 1'b1, we: 1'b1, addr: 7'h7f,   wdata: 8'hff, exp_rd: 8'h00};
    tbl[4] = '{who: 1'b1, we: 1'b0, addr: 7'h7f,   wdata: 8'h00, exp_rd: 8'hff};
    tbl[5] = '{who: 1'b0, we: 1'b0, addr: 7'd0,    wdata: 8'h00, exp_rd: 8'h01};
    tbl[6] = '{who: 1'b0, we: 1'b1, addr: 7'h40,   wdata: 8'ha5, exp_rd: 8'h00};
    tbl[7] = '{who: 1'b1, we: 1'b0, addr: 7'h40,   wdata: 8'h00, exp_rd: 8'ha5};

    for (int i = 0; i < 128; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    {a_req1, a_we1, a_addr1, a_wdata1, b_req1, b_we1, b_addr1, b_wdata1} = '0;
    {a_req3, a_we3, a_addr3, a_wdata3, b_req3, b_we3, b_addr3, b_wdata3} = '0;
    exp_ra = 8'h00;
    exp_rb = 8'h00;
    rst1 = 1'b1;
    rst3 = 1'b1;

    // Reset values before any clock edge (asynchronous reset).
    #1;
    chk_reset1("reset");
    chk("reset dut3 CS_D", 32'(csn3), 1);
    chk("reset dut3 BUSY", 32'(busy3), 0);

    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;

    foreach (tbl[i])
      access1(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd,
              $sformatf("vec%0d", i));

    // STROBE_CYCLES=3 with mid-access request changes.
    access3(1'b1, 7'd5, 8'h5a, k, lows, bad);
    chk("s3 write latency", k, S3 + 2);
    chk("s3 write strobe len", lows, S3);
    chk("s3 write bus latched", 32'(bad), 0);
    @(negedge clk);
    chk("s3 ack pulse", 32'(a_ack3), 0);
    access3(1'b0, 7'd5, 8'h00, k, lows, bad);
    chk("s3 read latency", k, S3 + 2);
    chk("s3 read strobe len", lows, S3);
    chk("s3 read bus latched", 32'(bad), 0);
    chk("s3 read data", 32'(a_rdata3), 32'h5a);
    chk("s3 B_RDATA untouched", 32'(b_rdata3), 0);

    // Conflict from reset: A first, then B; grant on first edge after reset release.
    @(negedge clk);
    rst1 = 1'b1;
    exp_ra = 8'h00;
    exp_rb = 8'h00;
    @(negedge clk);
    rst1 = 1'b0;
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 7'd10; a_wdata1 = 8'h11;
    b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 7'd11; b_wdata1 = 8'h22;
    wait_ack1(k, acks, lows, snap, unstable);
    a_req1 = 1'b0;
    chk("conflict1 first owner", 32'(acks), 2'b10);
    chk("conflict1 first latency", k, S1 + 2);
    chk("conflict1 first bus", 32'(snap), 32'({1'b1, 1'b0, 7'd10, 8'h11}));
    wait_ack1(k, acks, lows, snap, unstable);
    b_req1 = 1'b0;
    chk("conflict1 second owner", 32'(acks), 2'b01);
    chk("conflict1 second spacing", k, S1 + 3);
    chk("conflict1 second bus", 32'(snap), 32'({1'b1, 1'b0, 7'd11, 8'h22}));
    @(negedge clk);
    access1(1'b0, 1'b1, 7'd12, 8'h33, 8'h00, "a_only");

    // A was granted last: the next conflict goes to B.
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 7'd13; a_wdata1 = 8'h44;
    b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 7'd14; b_wdata1 = 8'h55;
    wait_ack1(k, acks, lows, snap, unstable);
    b_req1 = 1'b0;
    chk("conflict2 first owner", 32'(acks), 2'b01);
    chk("conflict2 first latency", k, S1 + 2);
    wait_ack1(k, acks, lows, snap, unstable);
    a_req1 = 1'b0;
    chk("conflict2 second owner", 32'(acks), 2'b10);
    chk("conflict2 second bus", 32'(snap), 32'({1'b1, 1'b0, 7'd13, 8'h44}));
    @(negedge clk);
    access1(1'b1, 1'b0, 7'd14, 8'h00, 8'h55, "conflict2 readback");

    // A request raised during B's strobe and withdrawn before it could be granted.
    @(negedge clk);
    b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 7'd1;
    @(negedge clk);
    @(negedge clk);
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 7'd1; a_wdata1 = 8'hee;
    wait_ack1(k, acks, lows, snap, unstable);
    a_req1 = 1'b0;
    b_req1 = 1'b0;
    chk("withdraw B owner", 32'(acks), 2'b01);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy1 || a_ack1 || b_ack1 || !csn1) quiet++;
    end
    chk("withdraw no access", quiet, 0);
    access1(1'b1, 1'b0, 7'd1, 8'h00, 8'h03, "withdraw mem intact");

    // A holds REQ continuously: one access every 3+STROBE_CYCLES cycles.
    @(negedge clk);
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 7'd20; a_wdata1 = 8'h44;
    wait_ack1(k, acks, lows, snap, unstable);
    chk("b2b first latency", k, S1 + 2);
    for (int i = 0; i < 2; i++) begin
      wait_ack1(k, acks, lows, snap, unstable);
      chk($sformatf("b2b%0d owner", i), 32'(acks), 2'b10);
      chk($sformatf("b2b%0d spacing", i), k, S1 + 3);
      chk($sformatf("b2b%0d strobe len", i), lows, S1);
    end
    a_req1 = 1'b0;
    @(negedge clk);
    chk("b2b stops after drop", 32'(busy1), 0);

    // Reset during STROBE aborts the access.
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 7'd2; a_wdata1 = 8'h77;
    k = 0;
    while (csn1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("midrst reached strobe", 32'(csn1), 0);
    #2 rst1 = 1'b1;
    #1;
    chk_reset1("midrst");
    a_req1 = 1'b0;
    exp_ra = 8'h00;
    exp_rb = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy1 || a_ack1 || b_ack1) quiet++;
    end
    chk("midrst no ack", quiet, 0);
    access1(1'b0, 1'b1, 7'd3, 8'h66, 8'h00, "postrst write");
    access1(1'b0, 1'b0, 7'd3, 8'h00, 8'h66, "postrst read");
    access1(1'b0, 1'b0, 7'd2, 8'h00, 8'h00, "aborted write absent");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsram_arb.md
DSRAM_ARB -- requirements
Module: dsram_arb

Interface
REQ-001 Parameter STROBE_CYCLES, default 1, number of clocks CS_D is held low per access; legal range 1..4.
REQ-002 CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 A_REQ  input  1  requester A (CPU) access request; level, held until A_ACK.
REQ-005 A_WE  input  1  requester A direction: 1 write, 0 read.
REQ-006 A_ADDR  input  7  requester A word address.
REQ-007 A_WDATA  input  8  requester A write data.
REQ-008 A_ACK  output  1  one-cycle pulse, A access complete.
REQ-009 A_RDATA  output  8  read data for A, valid from A_ACK cycle until A's next ACK.
REQ-010 B_REQ, B_WE, B_ADDR[6:0], B_WDATA[7:0], B_ACK, B_RDATA[7:0]: requester B (loader), same directions, widths and meanings as A.
REQ-011 WD  output  1  SRAM write enable to DATA_SRAM.
REQ-012 RD  output  1  SRAM read enable to DATA_SRAM.
REQ-013 CS_D  output  1  SRAM chip select, active-low strobe.
REQ-014 DIN  output  8  SRAM write data.
REQ-015 ADDR  output  7  SRAM address.
REQ-016 DOUT  input  8  SRAM read data.
REQ-017 BUSY  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, SETUP, STROBE, HOLD; all outputs registered.
REQ-019 IDLE: if any REQ high, select winner, latch its WE/ADDR/WDATA into internal registers, go SETUP; else stay IDLE.
REQ-020 Arbitration: single request wins directly; both high -> round-robin, grant the requester not granted last; last-grant pointer resets to B so A wins the first conflict.
REQ-021 Requester inputs are ignored from grant until ACK; changes to ADDR/WDATA/WE after latch do not affect the access.
REQ-022 SETUP (1 cycle): ADDR, DIN driven from latched values; WD=WE, RD=~WE; CS_D=1; go STROBE.
REQ-023 STROBE: CS_D=0 for exactly STROBE_CYCLES cycles via down-counter; ADDR/DIN/WD/RD stable throughout; go HOLD when counter expires.
REQ-024 Read: DOUT sampled on the last clock edge of STROBE into winner's RDATA register; other requester's RDATA unchanged.
REQ-025 HOLD (1 cycle): CS_D=1, ADDR/DIN/WD/RD still stable (address hold), winner's ACK=1; go IDLE.
REQ-026 IDLE drives CS_D=1, WD=0, RD=0; ADDR/DIN keep last values.
REQ-027 Access latency: REQ seen in IDLE at edge N -> ACK high in cycle N+2+STROBE_CYCLES; back-to-back throughput one access per 3+STROBE_CYCLES cycles.
REQ-028 Requester dropping REQ in its ACK cycle causes no further access; REQ still high in the cycle after ACK is a new request.
REQ-029 REQ deasserted before grant is a withdrawn request; no access, no ACK.
REQ-030 CS_D never low for two accesses without at least one high cycle between (SETUP guarantees it).
REQ-031 A_ACK and B_ACK never high in the same cycle.

Reset
REQ-032 RST high forces, immediately and independent of CLK: state IDLE, CS_D=1, WD=0, RD=0, ADDR=0, DIN=0, A_ACK=B_ACK=0, A_RDATA=B_RDATA=0, BUSY=0, last-grant=B, strobe counter 0.
REQ-033 RST during STROBE aborts the access: CS_D returns to 1 asynchronously, no ACK issued; requester must re-request after reset.
REQ-034 First grant possible on the first rising edge after RST deasserts.

Verification
REQ-035 A write: A_REQ=1, A_WE=1, A_ADDR=0, A_WDATA=0x01 -> one CS_D low pulse of STROBE_CYCLES with WD=1, RD=0, ADDR=0, DIN=0x01; A_ACK one pulse at N+3 (STROBE_CYCLES=1).
REQ-036 B write ADDR=1 data 0x03, then A read ADDR=1 -> RD=1, WD=0, A_RDATA=0x03 at A_ACK; B_RDATA unchanged.
REQ-037 A and B request in same cycle from reset -> A served first, B served next with no IDLE-to-grant gap beyond one cycle; second conflict -> B wins after A was last.
REQ-038 STROBE_CYCLES=3: CS_D low exactly 3 cycles, ACK at N+5; ADDR changed by requester mid-access has no effect.
REQ-039 RST asserted mid-STROBE -> CS_D=1, all outputs at reset values same cycle, no ACK; new request after reset completes normally.
REQ-040 A holds REQ high continuously with B idle -> back-to-back accesses every 3+STROBE_CYCLES cycles, CS_D high at least one cycle between strobes.
